// File: rtl/multdiv_ctrl_pkg.sv
// Shared constants, state type and helpers for the multdiv sequencer.
// TIMEOUT exists only when MULTDIV_CTRL_TIMEOUT_EN is defined.
package multdiv_ctrl_pkg;

    localparam logic [4:0]  OP_MUL  = 5'd6;
    localparam logic [4:0]  OP_DIV  = 5'd7;
    localparam logic [4:0]  EXC_REG = 5'd30;
    localparam logic [31:0] EXC_MUL = 32'd4;
    localparam logic [31:0] EXC_DIV = 32'd5;
`ifdef MULTDIV_CTRL_TIMEOUT_EN
    localparam logic [5:0]  TIMEOUT = 6'd40;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_WB    = 2'd3
    } md_state_t;

    function automatic logic is_multdiv_op(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    function automatic logic [31:0] exc_code(input logic is_div);
        return is_div ? EXC_DIV : EXC_MUL;
    endfunction

endpackage

// File: rtl/multdiv_hazard_check.sv
// RAW hazard detect: decode sources against the pending multdiv destination.
// r0 is never a hazard since it is hardwired to zero.
module multdiv_hazard_check
    import multdiv_ctrl_pkg::*;
(
    input  logic       i_busy,
    input  logic [4:0] i_pend_rd,
    input  logic [4:0] i_rs1,
    input  logic [4:0] i_rs2,
    output logic       o_raw_hazard
);

    always_comb begin
        o_raw_hazard = i_busy && (i_pend_rd != '0) &&
                       ((i_rs1 == i_pend_rd) || (i_rs2 == i_pend_rd));
    end

endmodule

// File: rtl/multdiv_ctrl.sv
// Multdiv sequencer: accept MUL/DIV, pulse start, wait for result, write back.
// Optional WAIT timeout enabled by defining MULTDIV_CTRL_TIMEOUT_EN.
module multdiv_ctrl
    import multdiv_ctrl_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic [4:0]  alu_op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic        flush,
    input  logic        md_ready,
    input  logic        md_exception,
    input  logic [31:0] md_result,
    output logic        ctrl_mult,
    output logic        ctrl_div,
    output logic        stall,
    output logic        busy,
    output logic        wb_en,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data
);

    md_state_t  r_state;
    logic       r_is_div;
    logic [4:0] r_rd;
`ifdef MULTDIV_CTRL_TIMEOUT_EN
    logic [5:0] r_wait_cnt;
`endif

    logic w_issue_md;
    logic w_accept;
    logic w_raw_hazard;

    always_comb begin
        w_issue_md = issue_valid && is_multdiv_op(alu_op);
        w_accept   = (r_state == S_IDLE) && w_issue_md && !flush;
    end

    multdiv_hazard_check u_hazard (
        .i_busy       (busy),
        .i_pend_rd    (r_rd),
        .i_rs1        (rs1),
        .i_rs2        (rs2),
        .o_raw_hazard (w_raw_hazard)
    );

    always_comb begin
        stall = (r_state == S_WB) || (busy && w_issue_md) || w_raw_hazard;
    end

    // Outputs are registered on the transition into the state that owns them.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_is_div  <= 1'b0;
            r_rd      <= '0;
            ctrl_mult <= 1'b0;
            ctrl_div  <= 1'b0;
            busy      <= 1'b0;
            wb_en     <= 1'b0;
            wb_rd     <= '0;
            wb_data   <= '0;
`ifdef MULTDIV_CTRL_TIMEOUT_EN
            r_wait_cnt <= '0;
`endif
        end else begin
            ctrl_mult <= 1'b0;
            ctrl_div  <= 1'b0;
            wb_en     <= 1'b0;
            wb_rd     <= '0;
            wb_data   <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state   <= S_START;
                        r_is_div  <= (alu_op == OP_DIV);
                        r_rd      <= rd;
                        busy      <= 1'b1;
                        ctrl_mult <= (alu_op == OP_MUL);
                        ctrl_div  <= (alu_op == OP_DIV);
                    end
                end
                S_START: begin
                    r_state <= S_WAIT;
`ifdef MULTDIV_CTRL_TIMEOUT_EN
                    r_wait_cnt <= '0;
`endif
                end
                S_WAIT: begin
                    if (md_ready) begin
                        r_state <= S_WB;
                        if (md_exception) begin
                            wb_en   <= 1'b1;
                            wb_rd   <= EXC_REG;
                            wb_data <= exc_code(r_is_div);
                        end else begin
                            wb_en   <= (r_rd != '0);
                            wb_rd   <= r_rd;
                            wb_data <= md_result;
                        end
                    end
`ifdef MULTDIV_CTRL_TIMEOUT_EN
                    else if (r_wait_cnt == (TIMEOUT - 6'd1)) begin
                        r_state <= S_WB;
                        wb_en   <= 1'b1;
                        wb_rd   <= EXC_REG;
                        wb_data <= exc_code(r_is_div);
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 6'd1;
                    end
`endif
                end
                S_WB: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Self-checking bench for multdiv_ctrl using a transaction-timeline reference.
// Timeout scenario is compiled in only with MULTDIV_CTRL_TIMEOUT_EN.
module tb_multdiv_ctrl;

    localparam logic [4:0] L_MUL = 5'd6;
    localparam logic [4:0] L_DIV = 5'd7;

    logic        clock = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic [4:0]  alu_op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        flush;
    logic        md_ready;
    logic        md_exception;
    logic [31:0] md_result;
    logic        ctrl_mult;
    logic        ctrl_div;
    logic        stall;
    logic        busy;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    multdiv_ctrl dut (
        .clock        (clock),
        .reset        (reset),
        .issue_valid  (issue_valid),
        .alu_op       (alu_op),
        .rd           (rd),
        .rs1          (rs1),
        .rs2          (rs2),
        .flush        (flush),
        .md_ready     (md_ready),
        .md_exception (md_exception),
        .md_result    (md_result),
        .ctrl_mult    (ctrl_mult),
        .ctrl_div     (ctrl_div),
        .stall        (stall),
        .busy         (busy),
        .wb_en        (wb_en),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        issue_valid  = 1'b0;
        alu_op       = 5'd0;
        rd           = 5'd0;
        rs1          = 5'd0;
        rs2          = 5'd0;
        flush        = 1'b0;
        md_ready     = 1'b0;
        md_exception = 1'b0;
        md_result    = 32'd0;
    endtask

    // One operation from its IDLE issue cycle through its WB cycle.
    // Cycle 1 is the start pulse, then n_wait quiet WAIT cycles, then md_ready,
    // then WB. dmode: 0 random decode noise, 1 fixed rs1/rs2, 2 next MD op held.
    task automatic run_op(input logic [4:0] op, input logic [4:0] d_rd,
                          input int n_wait, input bit exc, input logic [31:0] res,
                          input int dmode, input logic [4:0] frs1, input logic [4:0] frs2);
        int          total;
        bit          in_wb;
        bit          last_wait;
        logic        exp_stall;
        logic        exp_en;
        logic [4:0]  exp_rd;
        logic [31:0] exp_data;
        issue_valid  = 1'b1;
        alu_op       = op;
        rd           = d_rd;
        flush        = 1'b0;
        rs1          = 5'($urandom_range(0, 31));
        rs2          = 5'($urandom_range(0, 31));
        md_ready     = 1'($urandom_range(0, 1));
        md_exception = 1'($urandom_range(0, 1));
        md_result    = $urandom;
        #1;
        n_checks++;
        if ({busy, stall, wb_en, ctrl_mult, ctrl_div} !== 5'b0 || wb_rd !== 5'd0 || wb_data !== 32'd0)
            begin
                n_errors++;
                $display("FAIL idle_before_issue t=%0t busy=%b stall=%b wb_en=%b cm=%b cd=%b wb_rd=%0d wb_data=%h exp all 0",
                         $time, busy, stall, wb_en, ctrl_mult, ctrl_div, wb_rd, wb_data);
            end
        tick();
        total = n_wait + 3;
        for (int c = 1; c <= total; c++) begin
            in_wb     = (c == total);
            last_wait = (c == total - 1);
            case (dmode)
                0: begin
                    issue_valid = 1'($urandom_range(0, 1));
                    alu_op      = 5'($urandom_range(4, 9));
                    rd          = 5'($urandom_range(0, 31));
                    rs1         = 5'($urandom_range(0, 7));
                    rs2         = 5'($urandom_range(0, 7));
                    flush       = 1'($urandom_range(0, 1));
                end
                1: begin
                    issue_valid = 1'b0;
                    rs1         = frs1;
                    rs2         = frs2;
                    flush       = 1'b0;
                end
                default: begin
                    issue_valid = 1'b1;
                    alu_op      = L_DIV;
                    rd          = 5'd12;
                    rs1         = d_rd ^ 5'd1;
                    rs2         = d_rd ^ 5'd1;
                    flush       = 1'b0;
                end
            endcase
            if (last_wait) begin
                md_ready     = 1'b1;
                md_exception = exc;
                md_result    = res;
            end else begin
                md_ready     = (c == 1 || in_wb) ? 1'($urandom_range(0, 1)) : 1'b0;
                md_exception = 1'($urandom_range(0, 1));
                md_result    = $urandom;
            end
            exp_stall = in_wb || (issue_valid && (alu_op == L_MUL || alu_op == L_DIV)) ||
                        (d_rd != 5'd0 && (rs1 == d_rd || rs2 == d_rd));
            #1;
            n_checks++;
            if (stall !== exp_stall) begin
                n_errors++;
                $display("FAIL stall c=%0d t=%0t got=%b exp=%b", c, $time, stall, exp_stall);
            end
            n_checks++;
            if (busy !== 1'b1) begin
                n_errors++;
                $display("FAIL busy c=%0d t=%0t got=%b exp=1", c, $time, busy);
            end
            n_checks++;
            if (ctrl_mult !== (c == 1 && op == L_MUL) || ctrl_div !== (c == 1 && op == L_DIV)) begin
                n_errors++;
                $display("FAIL start_pulse c=%0d t=%0t mult=%b div=%b exp_mult=%b exp_div=%b", c, $time,
                         ctrl_mult, ctrl_div, (c == 1 && op == L_MUL), (c == 1 && op == L_DIV));
            end
            if (in_wb) begin
                exp_en   = exc ? 1'b1 : (d_rd != 5'd0);
                exp_rd   = exc ? 5'd30 : d_rd;
                exp_data = exc ? ((op == L_DIV) ? 32'd5 : 32'd4) : res;
                n_checks++;
                if (wb_en !== exp_en) begin
                    n_errors++;
                    $display("FAIL wb_en c=%0d t=%0t got=%b exp=%b", c, $time, wb_en, exp_en);
                end
                n_checks++;
                if (wb_rd !== exp_rd) begin
                    n_errors++;
                    $display("FAIL wb_rd c=%0d t=%0t got=%0d exp=%0d", c, $time, wb_rd, exp_rd);
                end
                if (exp_en) begin
                    n_checks++;
                    if (wb_data !== exp_data) begin
                        n_errors++;
                        $display("FAIL wb_data c=%0d t=%0t got=%h exp=%h", c, $time, wb_data, exp_data);
                    end
                end
            end else begin
                n_checks++;
                if (wb_en !== 1'b0 || wb_rd !== 5'd0 || wb_data !== 32'd0) begin
                    n_errors++;
                    $display("FAIL wb_quiet c=%0d t=%0t wb_en=%b wb_rd=%0d wb_data=%h exp 0", c, $time,
                             wb_en, wb_rd, wb_data);
                end
            end
            tick();
        end
    endtask

    task automatic check_idle(input string tag);
        #1;
        n_checks++;
        if ({busy, stall, wb_en, ctrl_mult, ctrl_div} !== 5'b0 || wb_rd !== 5'd0 || wb_data !== 32'd0)
            begin
                n_errors++;
                $display("FAIL %s t=%0t busy=%b stall=%b wb_en=%b cm=%b cd=%b wb_rd=%0d wb_data=%h exp all 0",
                         tag, $time, busy, stall, wb_en, ctrl_mult, ctrl_div, wb_rd, wb_data);
            end
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        check_idle("reset_state");
        @(negedge clock);
        reset = 1'b0;
        tick();
        check_idle("after_reset_release");
    endtask

    task automatic test_mul_directed();
        run_op(L_MUL, 5'd5, 33, 1'b0, 32'h0000_0C00, 1, 5'd0, 5'd0);
        idle_inputs();
        check_idle("mul_busy_drop");
        tick();
    endtask

    task automatic test_div_exception();
        run_op(L_DIV, 5'd7, 5, 1'b1, 32'hDEAD_BEEF, 1, 5'd0, 5'd0);
        idle_inputs();
        check_idle("div_exc_after_wb");
        tick();
    endtask

    task automatic test_raw();
        run_op(L_MUL, 5'd3, 6, 1'b0, 32'h1234_5678, 1, 5'd0, 5'd3);
        run_op(L_MUL, 5'd3, 4, 1'b0, 32'h0000_0042, 1, 5'd3, 5'd0);
        run_op(L_MUL, 5'd0, 4, 1'b0, 32'h0000_0099, 1, 5'd0, 5'd0);
        idle_inputs();
        check_idle("raw_after_rd0");
        tick();
    endtask

    task automatic test_flush_and_ignore();
        idle_inputs();
        issue_valid = 1'b1;
        alu_op      = L_MUL;
        rd          = 5'd4;
        flush       = 1'b1;
        tick();
        idle_inputs();
        check_idle("flushed_issue");
        issue_valid = 1'b1;
        alu_op      = 5'd5;
        rd          = 5'd4;
        tick();
        idle_inputs();
        check_idle("non_md_op_ignored");
        tick();
    endtask

    task automatic test_back_to_back();
        run_op(L_MUL, 5'd9, 3, 1'b0, 32'hCAFE_0001, 2, 5'd0, 5'd0);
        run_op(L_DIV, 5'd12, 2, 1'b0, 32'hCAFE_0002, 1, 5'd0, 5'd0);
        idle_inputs();
        check_idle("b2b_after_second");
        tick();
    endtask

    task automatic test_reset_mid_wait();
        idle_inputs();
        issue_valid = 1'b1;
        alu_op      = L_MUL;
        rd          = 5'd6;
        tick();
        idle_inputs();
        repeat (3) tick();
        reset = 1'b1;
        check_idle("reset_mid_wait_async");
        @(negedge clock);
        reset        = 1'b0;
        md_ready     = 1'b1;
        md_result    = 32'h0000_1111;
        tick();
        check_idle("reset_mid_wait_no_wb1");
        tick();
        check_idle("reset_mid_wait_no_wb2");
        idle_inputs();
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++) begin
            run_op(($urandom_range(0, 1) == 0) ? L_MUL : L_DIV, 5'($urandom_range(0, 31)),
                   int'($urandom_range(0, 39)), ($urandom_range(0, 3) == 0), $urandom,
                   0, 5'd0, 5'd0);
            if ($urandom_range(0, 2) == 0) begin
                idle_inputs();
                check_idle("random_gap");
                tick();
            end
        end
        run_op(L_DIV, 5'd21, 39, 1'b0, 32'h0BAD_F00D, 1, 5'd0, 5'd0);
        idle_inputs();
        check_idle("ready_on_last_count");
        tick();
    endtask

`ifdef MULTDIV_CTRL_TIMEOUT_EN
    task automatic test_timeout();
        idle_inputs();
        issue_valid = 1'b1;
        alu_op      = L_MUL;
        rd          = 5'd8;
        tick();
        idle_inputs();
        for (int c = 1; c <= 42; c++) begin
            #1;
            n_checks++;
            if (c < 42 && (wb_en !== 1'b0 || busy !== 1'b1)) begin
                n_errors++;
                $display("FAIL timeout_wait c=%0d wb_en=%b busy=%b exp wb_en=0 busy=1", c, wb_en, busy);
            end else if (c == 42 && (wb_en !== 1'b1 || wb_rd !== 5'd30 || wb_data !== 32'd4)) begin
                n_errors++;
                $display("FAIL timeout_wb wb_en=%b wb_rd=%0d wb_data=%h exp 1/30/00000004", wb_en, wb_rd, wb_data);
            end
            tick();
        end
        check_idle("timeout_after_wb");
        tick();
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached at t=%0t", $time);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_mul_directed();
        test_div_exception();
        test_raw();
        test_flush_and_ignore();
        test_back_to_back();
        test_reset_mid_wait();
        test_random();
`ifdef MULTDIV_CTRL_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
